// File: rtl/noc_pkg.sv
// Shared NoC types: VC count, flit format, flit labels and per-VC packet states.
package noc_pkg;

  localparam int VC_NUM    = 2;
  localparam int VC_ID_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PAYLOAD_W = 32;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } vc_state_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_ID_W-1:0]   vc_id;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  // True for the last flit of a packet.
  function automatic logic is_tail(input flit_label_t lbl);
    return (lbl == TAIL) || (lbl == HEADTAIL);
  endfunction

endpackage

// File: rtl/router2router.sv
// Router-to-router link: flit bus forward, per-VC on/off and allocatable credits back.
interface router2router;
  import noc_pkg::*;

  flit_t               data;
  logic                is_valid;
  logic [VC_NUM-1:0]   is_on_off;
  logic [VC_NUM-1:0]   is_allocatable;

  modport upstream (
    output data,
    output is_valid,
    input  is_on_off,
    input  is_allocatable
  );

  modport downstream (
    input  data,
    input  is_valid,
    output is_on_off,
    output is_allocatable
  );

endinterface

// File: rtl/circular_buffer.sv
// Single first-word-fall-through flit FIFO with occupancy count.
module circular_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  flit_t                    data_i,
  output flit_t                    data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  flit_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              pop_eff;
  logic              push_eff;

  // A pop on empty is ignored; a push on full is only taken when a pop frees a slot.
  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Head is read straight from storage so a write is visible the next cycle.
  assign data_o  = mem_q[rd_ptr_q];

  // Flit storage, not reset: validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Per-VC input buffering with packet-state tracking, on/off flow control and error flags.
module vc_input_buffer
  import noc_pkg::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int OFF_MARGIN  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  router2router.downstream    up,
  input  logic [VC_NUM-1:0]   rd_en,
  output flit_t               out_flit [VC_NUM],
  output logic [VC_NUM-1:0]   out_valid,
  output logic                err_overflow,
  output logic                err_protocol
);

  localparam int               CNT_W      = $clog2(BUFFER_SIZE) + 1;
  localparam logic [CNT_W-1:0] OFF_THRESH = CNT_W'(BUFFER_SIZE - OFF_MARGIN);

  logic [VC_NUM-1:0] on_off_w;
  logic [VC_NUM-1:0] alloc_w;
  logic [VC_NUM-1:0] overflow_w;
  logic [VC_NUM-1:0] proto_w;
  logic              err_overflow_q;
  logic              err_protocol_q;

  genvar gi;
  for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
    logic             push;
    logic             pop;
    logic             accept;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    flit_label_t      label;
    flit_label_t      head_label;
    vc_state_t        state_q;
    vc_state_t        state_d;
    logic             alloc_q;
    logic             on_off_q;
    logic             proto_err;

    assign push       = up.is_valid && (up.data.vc_id == VC_ID_W'(gi));
    assign pop        = rd_en[gi] & ~empty;
    assign accept     = push & (~full | pop);
    assign label      = up.data.flit_label;
    assign head_label = out_flit[gi].flit_label;

    circular_buffer #(
      .DEPTH (BUFFER_SIZE)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (rd_en[gi]),
      .data_i  (up.data),
      .data_o  (out_flit[gi]),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
    );

    // Occupancy after this edge, used to decide on/off one cycle ahead.
    always_comb begin
      count_d = count;
      if (accept && !pop)      count_d = count + CNT_W'(1);
      else if (!accept && pop) count_d = count - CNT_W'(1);
    end

    // Packet-state next state and protocol check; only stored flits advance the state.
    always_comb begin
      state_d   = state_q;
      proto_err = 1'b0;
      case (state_q)
        IDLE: begin
          if (push) begin
            if (label == BODY || label == TAIL) proto_err = 1'b1;
            else if (accept) state_d = (label == HEAD) ? ACTIVE : DRAIN;
          end
        end
        ACTIVE: begin
          if (push) begin
            if (label == HEAD || label == HEADTAIL) proto_err = 1'b1;
            else if (label == TAIL && accept)       state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (push && (label == HEAD || label == HEADTAIL)) proto_err = 1'b1;
          if (pop && is_tail(head_label)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // State register with registered allocatable and on/off outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= IDLE;
        alloc_q  <= 1'b1;
        on_off_q <= 1'b1;
      end else begin
        state_q  <= state_d;
        alloc_q  <= (state_d == IDLE);
        on_off_q <= (count_d < OFF_THRESH);
      end
    end

    assign on_off_w[gi]   = on_off_q;
    assign alloc_w[gi]    = alloc_q;
    assign overflow_w[gi] = push & full & ~pop;
    assign proto_w[gi]    = proto_err;
    assign out_valid[gi]  = ~empty;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_q <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      err_overflow_q <= err_overflow_q | (|overflow_w);
      err_protocol_q <= err_protocol_q | (|proto_w);
    end
  end

  assign err_overflow      = err_overflow_q;
  assign err_protocol      = err_protocol_q;
  assign up.is_on_off      = on_off_w;
  assign up.is_allocatable = alloc_w;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_vc_input_buffer;
  import noc_pkg::*;

  localparam int BS     = 8;
  localparam int MARGIN = 2;

  logic              clk;
  logic              rst_n;
  logic [VC_NUM-1:0] rd_en;
  flit_t             out_flit [VC_NUM];
  logic [VC_NUM-1:0] out_valid;
  logic              err_overflow;
  logic              err_protocol;

  router2router up_if();

  vc_input_buffer #(
    .BUFFER_SIZE (BS),
    .OFF_MARGIN  (MARGIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up           (up_if),
    .rd_en        (rd_en),
    .out_flit     (out_flit),
    .out_valid    (out_valid),
    .err_overflow (err_overflow),
    .err_protocol (err_protocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per VC, packet phase (0 idle, 1 open, 2 tail stored), sticky flags.
  flit_t q [VC_NUM][$];
  int    phase [VC_NUM];
  bit    m_ovf;
  bit    m_proto;

  task automatic model_clear();
    for (int k = 0; k < VC_NUM; k++) begin
      q[k].delete();
      phase[k] = 0;
    end
    m_ovf   = 1'b0;
    m_proto = 1'b0;
  endtask

  task automatic model_step(input logic vld, input flit_t f, input logic [VC_NUM-1:0] rd);
    bit popped [VC_NUM];
    bit ptail  [VC_NUM];
    int old_ph [VC_NUM];
    bit acc;
    int v;
    acc = 1'b0;
    v   = 0;
    for (int k = 0; k < VC_NUM; k++) begin
      old_ph[k] = phase[k];
      popped[k] = rd[k] && (q[k].size() > 0);
      ptail[k]  = popped[k] && (q[k][0].flit_label == TAIL || q[k][0].flit_label == HEADTAIL);
    end
    if (vld) begin
      v   = int'(f.vc_id);
      acc = (q[v].size() < BS) || popped[v];
      if (!acc) m_ovf = 1'b1;
      case (old_ph[v])
        0: begin
          if (f.flit_label == BODY || f.flit_label == TAIL) m_proto = 1'b1;
          else if (acc) phase[v] = (f.flit_label == HEAD) ? 1 : 2;
        end
        1: begin
          if (f.flit_label == HEAD || f.flit_label == HEADTAIL) m_proto = 1'b1;
          else if (f.flit_label == TAIL && acc) phase[v] = 2;
        end
        default: begin
          if (f.flit_label == HEAD || f.flit_label == HEADTAIL) m_proto = 1'b1;
        end
      endcase
    end
    for (int k = 0; k < VC_NUM; k++) begin
      if (popped[k]) void'(q[k].pop_front());
      if (old_ph[k] == 2 && ptail[k]) phase[k] = 0;
    end
    if (acc) q[v].push_back(f);
  endtask

  // One clock: drive at negedge, update model at posedge, return at next negedge.
  task automatic cycle(input logic vld, input int vc, input flit_label_t lbl,
                       input logic [31:0] pl, input logic [VC_NUM-1:0] rd);
    flit_t f;
    f.flit_label     = lbl;
    f.vc_id          = VC_ID_W'(vc);
    f.payload        = pl;
    up_if.data       = f;
    up_if.is_valid   = vld;
    rd_en            = rd;
    @(posedge clk);
    model_step(vld, f, rd);
    @(negedge clk);
    up_if.is_valid   = 1'b0;
    rd_en            = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
    n_tests++;
    if (up_if.is_on_off !== 2'b11) begin n_fail++; $display("FAIL reset_on_off got=%b exp=11", up_if.is_on_off); end
    n_tests++;
    if (up_if.is_allocatable !== 2'b11) begin n_fail++; $display("FAIL reset_alloc got=%b exp=11", up_if.is_allocatable); end
    n_tests++;
    if ({err_overflow, err_protocol} !== 2'b00) begin
      n_fail++; $display("FAIL reset_errs got=%b exp=00", {err_overflow, err_protocol});
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle got=%b exp=00", out_valid); end
  endtask

  task automatic test_packet();
    flit_label_t lbl [3];
    lbl[0] = HEAD; lbl[1] = BODY; lbl[2] = TAIL;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 0, lbl[i], 32'hA000 + i, 2'b00);
      n_tests++;
      if (out_valid[0] !== 1'b1 || out_flit[0].payload !== 32'hA000) begin
        n_fail++; $display("FAIL packet_write%0d valid=%b payload=%h exp 1/a000", i, out_valid[0], out_flit[0].payload);
      end
      n_tests++;
      if (up_if.is_allocatable[0] !== 1'b0) begin
        n_fail++; $display("FAIL packet_alloc_w%0d got=%b exp=0", i, up_if.is_allocatable[0]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_flit[0].payload !== 32'hA000 + i || out_flit[0].flit_label !== lbl[i]) begin
        n_fail++; $display("FAIL packet_order%0d got=%h exp=%h", i, out_flit[0].payload, 32'hA000 + i);
      end
      cycle(1'b0, 0, HEAD, 32'h0, 2'b01);
      n_tests++;
      if (up_if.is_allocatable[0] !== (i == 2)) begin
        n_fail++; $display("FAIL packet_alloc_p%0d got=%b exp=%b", i, up_if.is_allocatable[0], (i == 2));
      end
    end
    n_tests++;
    if (out_valid !== 2'b00) begin n_fail++; $display("FAIL packet_empty got=%b exp=00", out_valid); end
  endtask

  task automatic test_onoff();
    do_reset();
    for (int i = 0; i < BS - MARGIN; i++) begin
      cycle(1'b1, 0, (i == 0) ? HEAD : BODY, 32'hB000 + i, 2'b00);
      n_tests++;
      if (up_if.is_on_off[0] !== (i < BS - MARGIN - 1)) begin
        n_fail++; $display("FAIL onoff_w%0d got=%b exp=%b", i, up_if.is_on_off[0], (i < BS - MARGIN - 1));
      end
    end
    cycle(1'b0, 0, HEAD, 32'h0, 2'b01);
    n_tests++;
    if (up_if.is_on_off[0] !== 1'b1) begin n_fail++; $display("FAIL onoff_pop got=%b exp=1", up_if.is_on_off[0]); end
    n_tests++;
    if (up_if.is_on_off[1] !== 1'b1) begin n_fail++; $display("FAIL onoff_vc1 got=%b exp=1", up_if.is_on_off[1]); end
  endtask

  task automatic test_overflow();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < BS; i++) cycle(1'b1, 1, (i == 0) ? HEAD : BODY, 32'hC000 + i, 2'b00);
      n_tests++;
      if (err_overflow !== 1'b0 || out_valid !== 2'b10) begin
        n_fail++; $display("FAIL ovf_fill%0d err=%b valid=%b exp 0/10", pass, err_overflow, out_valid);
      end
      cycle(1'b1, 1, BODY, 32'hDEAD, (pass == 0) ? 2'b00 : 2'b10);
      n_tests++;
      if (err_overflow !== (pass == 0)) begin
        n_fail++; $display("FAIL ovf_ninth%0d err=%b exp=%b", pass, err_overflow, (pass == 0));
      end
      for (int i = 0; i < BS; i++) begin
        n_tests++;
        if (out_valid[1] !== 1'b1 || out_flit[1].payload !== q[1][0].payload) begin
          n_fail++; $display("FAIL ovf_drain%0d_%0d valid=%b got=%h exp=%h", pass, i, out_valid[1], out_flit[1].payload, q[1][0].payload);
        end
        cycle(1'b0, 0, HEAD, 32'h0, 2'b10);
      end
      n_tests++;
      if (out_valid !== 2'b00) begin n_fail++; $display("FAIL ovf_count%0d valid=%b exp=00", pass, out_valid); end
    end
  endtask

  task automatic test_interleave();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cycle(1'b1, 0, (i == 0) ? HEAD : BODY, 32'h0000_0000 + i, 2'b11);
      else            cycle(1'b1, 1, HEADTAIL, 32'h1111_0000 + i, 2'b11);
      for (int k = 0; k < VC_NUM; k++) begin
        n_tests++;
        if (out_valid[k] !== (q[k].size() > 0)) begin
          n_fail++; $display("FAIL ilv_valid c%0d vc%0d got=%b exp=%b", i, k, out_valid[k], (q[k].size() > 0));
        end
        if (q[k].size() > 0) begin
          n_tests++;
          if (out_flit[k] !== q[k][0] || int'(out_flit[k].vc_id) != k) begin
            n_fail++; $display("FAIL ilv_flit c%0d vc%0d got=%h exp=%h", i, k, out_flit[k], q[k][0]);
          end
        end
        n_tests++;
        if (up_if.is_allocatable[k] !== (phase[k] == 0)) begin
          n_fail++; $display("FAIL ilv_alloc c%0d vc%0d got=%b exp=%b", i, k, up_if.is_allocatable[k], (phase[k] == 0));
        end
      end
    end
    cycle(1'b0, 0, HEAD, 32'h0, 2'b11);
    n_tests++;
    if (up_if.is_allocatable !== 2'b10 || err_protocol !== 1'b0) begin
      n_fail++; $display("FAIL ilv_final alloc=%b perr=%b exp 10/0", up_if.is_allocatable, err_protocol);
    end
  endtask

  task automatic test_protocol_reset();
    do_reset();
    cycle(1'b1, 0, BODY, 32'hE000, 2'b00);
    n_tests++;
    if (err_protocol !== 1'b1 || out_valid[0] !== 1'b1 || out_flit[0].payload !== 32'hE000) begin
      n_fail++; $display("FAIL proto_body perr=%b valid=%b payload=%h exp 1/1/e000", err_protocol, out_valid[0], out_flit[0].payload);
    end
    cycle(1'b1, 0, BODY, 32'hE001, 2'b00);
    cycle(1'b1, 1, HEAD, 32'hE002, 2'b00);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 2'b00 || up_if.is_on_off !== 2'b11 || up_if.is_allocatable !== 2'b11) begin
      n_fail++; $display("FAIL async_reset valid=%b onoff=%b alloc=%b exp 00/11/11", out_valid, up_if.is_on_off, up_if.is_allocatable);
    end
    n_tests++;
    if ({err_overflow, err_protocol} !== 2'b00) begin
      n_fail++; $display("FAIL async_reset_errs got=%b exp=00", {err_overflow, err_protocol});
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic              vld;
    int                vc;
    flit_label_t       lbl;
    logic [VC_NUM-1:0] rd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      vld = ($urandom_range(0, 9) < 7);
      vc  = int'($urandom_range(0, VC_NUM - 1));
      lbl = flit_label_t'($urandom_range(0, 3));
      for (int k = 0; k < VC_NUM; k++) rd[k] = ($urandom_range(0, 9) < ((i < 200) ? 3 : 7));
      cycle(vld, vc, lbl, $urandom, rd);
      for (int k = 0; k < VC_NUM; k++) begin
        n_tests++;
        if (out_valid[k] !== (q[k].size() > 0)) begin
          n_fail++; $display("FAIL rnd_valid c%0d vc%0d got=%b exp=%b", i, k, out_valid[k], (q[k].size() > 0));
        end
        if (q[k].size() > 0) begin
          n_tests++;
          if (out_flit[k] !== q[k][0]) begin
            n_fail++; $display("FAIL rnd_flit c%0d vc%0d got=%h exp=%h", i, k, out_flit[k], q[k][0]);
          end
        end
        n_tests++;
        if (up_if.is_on_off[k] !== (q[k].size() < BS - MARGIN)) begin
          n_fail++; $display("FAIL rnd_onoff c%0d vc%0d got=%b exp=%b", i, k, up_if.is_on_off[k], (q[k].size() < BS - MARGIN));
        end
        n_tests++;
        if (up_if.is_allocatable[k] !== (phase[k] == 0)) begin
          n_fail++; $display("FAIL rnd_alloc c%0d vc%0d got=%b exp=%b", i, k, up_if.is_allocatable[k], (phase[k] == 0));
        end
      end
      n_tests++;
      if (err_overflow !== m_ovf || err_protocol !== m_proto) begin
        n_fail++; $display("FAIL rnd_errs c%0d got=%b%b exp=%b%b", i, err_overflow, err_protocol, m_ovf, m_proto);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    rd_en          = '0;
    up_if.is_valid = 1'b0;
    up_if.data     = '0;
    model_clear();
    test_reset();
    test_packet();
    test_onoff();
    test_overflow();
    test_interleave();
    test_protocol_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
